// File: rtl/jstk_pkg.sv
// Shared constants and FSM encoding for the PmodJSTK SPI responder.
package jstk_pkg;

    localparam int       DEF_FRAME_BYTES = 5;
    localparam logic [5:0] DEF_CMD_PREFIX = 6'b100000;

    // Byte 0 of the incoming frame carries the LED command.
    localparam int       BYTE_BITS    = 8;
    localparam int       CMD_BYTE_IDX = 0;
    localparam int       TX_BITS      = 40;   // X lo, X hi, Y lo, Y hi, buttons

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        ERR   = 2'd3
    } state_t;

endpackage

// File: rtl/jstk_spi_responder_pin_sync.sv
// Multi-flop synchronizer for one SPI pin with registered rise/fall events.
// level is delayed to line up with the event pulses.
module spi_pin_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    assign level = prev_q;

    // Synchronize the pin and register edge events (pin-to-event = STAGES+1 clocks).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin};
            prev_q <= sync_q[STAGES-1];
            rise   <= sync_q[STAGES-1] & ~prev_q;
            fall   <= ~sync_q[STAGES-1] & prev_q;
        end
    end

endmodule

// File: rtl/jstk_spi_responder.sv
// SPI mode-0 responder emulating a PmodJSTK: serves X/Y/buttons, captures LED command.
// All SPI pins are oversampled on CLK; SCLK is never used as a clock.
module jstk_spi_responder
    import jstk_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         FRAME_BYTES = DEF_FRAME_BYTES,
    parameter logic [5:0] CMD_PREFIX  = DEF_CMD_PREFIX
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SS,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [9:0] X_POS,
    input  logic [9:0] Y_POS,
    input  logic [2:0] BTN,
    output logic [1:0] LED,
    output logic       FRAME_DONE,
    output logic       FRAME_ERR
);

    localparam logic [5:0] LAST_BIT    = 6'(FRAME_BYTES * BYTE_BITS - 1);
    localparam logic [5:0] CMD_LAST_BIT = 6'((CMD_BYTE_IDX + 1) * BYTE_BITS - 1);

    logic ss_lvl, ss_rise, ss_fall;
    logic sclk_lvl, sclk_rise_raw, sclk_fall_raw;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic unused_sync;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk(CLK), .rst_n(RST), .pin(SS),
        .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk(CLK), .rst_n(RST), .pin(SCLK),
        .level(sclk_lvl), .rise(sclk_rise_raw), .fall(sclk_fall_raw)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
        .clk(CLK), .rst_n(RST), .pin(MOSI),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

    // SCLK edges only count while selected, and an SS rise in the same cycle wins.
    logic sclk_rise, sclk_fall;
    assign sclk_rise = sclk_rise_raw & ~ss_lvl & ~ss_rise;
    assign sclk_fall = sclk_fall_raw & ~ss_lvl & ~ss_rise;

    state_t             state_q, state_d;
    logic [TX_BITS-1:0] tx_q;
    logic [7:0]         rx_q, rx_next, cmd_q;
    logic [5:0]         bit_cnt_q;
    logic               overrun_q;
    logic               led_load;
    logic [TX_BITS-1:0] snapshot;

    assign rx_next  = {rx_q[6:0], mosi_lvl};
    assign snapshot = {X_POS[7:0], 6'b0, X_POS[9:8],
                       Y_POS[7:0], 6'b0, Y_POS[9:8],
                       5'b0, BTN};

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (ss_fall) state_d = SHIFT;
            SHIFT: begin
                if (ss_rise)                               state_d = ERR;
                else if (sclk_rise && bit_cnt_q == LAST_BIT) state_d = DONE;
            end
            DONE:  if (ss_rise) state_d = IDLE;
            ERR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame-end pulses and LED update strobe.
    always_comb begin
        FRAME_DONE = 1'b0;
        FRAME_ERR  = 1'b0;
        led_load   = 1'b0;
        case (state_q)
            DONE: if (ss_rise) begin
                if (overrun_q) begin
                    FRAME_ERR = 1'b1;
                end else begin
                    FRAME_DONE = 1'b1;
                    led_load   = (cmd_q[7:2] == CMD_PREFIX);
                end
            end
            ERR:     FRAME_ERR = 1'b1;
            default: ;
        endcase
    end

    // Shifters, bit counter, command capture and MISO drive.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_q      <= '0;
            rx_q      <= '0;
            cmd_q     <= '0;
            bit_cnt_q <= '0;
            overrun_q <= 1'b0;
            MISO      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (ss_fall) begin
                    tx_q      <= snapshot;
                    MISO      <= snapshot[TX_BITS-1];
                    rx_q      <= '0;
                    bit_cnt_q <= '0;
                    overrun_q <= 1'b0;
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        rx_q      <= rx_next;
                        bit_cnt_q <= bit_cnt_q + 6'd1;
                        if (bit_cnt_q == CMD_LAST_BIT) cmd_q <= rx_next;
                    end else if (sclk_fall) begin
                        tx_q <= {tx_q[TX_BITS-2:0], 1'b0};
                        MISO <= tx_q[TX_BITS-2];
                    end
                end
                DONE: begin
                    MISO <= 1'b0;
                    if (sclk_rise) begin
                        rx_q      <= rx_next;
                        overrun_q <= 1'b1;
                        if (bit_cnt_q != 6'd63) bit_cnt_q <= bit_cnt_q + 6'd1;
                    end
                end
                default: MISO <= 1'b0;
            endcase
        end
    end

    // LED register only follows a well-formed frame with a matching prefix.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)          LED <= 2'b00;
        else if (led_load) LED <= cmd_q[1:0];
    end

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Scoreboard bench: a bit-level SPI master pushes expected MISO bits and
// frame events; independent monitors pop and compare.
module tb_jstk_spi_responder;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       SS = 1'b1, SCLK = 1'b0, MOSI = 1'b0;
    logic       MISO;
    logic [9:0] X_POS = '0, Y_POS = '0;
    logic [2:0] BTN = '0;
    logic [1:0] LED;
    logic       FRAME_DONE, FRAME_ERR;

    jstk_spi_responder dut (
        .CLK(CLK), .RST(RST), .SS(SS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .X_POS(X_POS), .Y_POS(Y_POS), .BTN(BTN), .LED(LED),
        .FRAME_DONE(FRAME_DONE), .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct { bit err; logic [1:0] led; } ev_t;
    ev_t  evq[$];
    logic bq[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // One master transaction: nbits SCLK pulses, cmd in byte 0, zeros after.
    task automatic frame(input int nbits, input logic [7:0] cmd, input logic [39:0] exp_tx,
                         input int chg_bit, input logic [9:0] chg_x,
                         input bit exp_err, input logic [1:0] exp_led);
        ev_t e;
        for (int i = 0; i < nbits; i++) bq.push_back(i < 40 ? exp_tx[39-i] : 1'b0);
        e.err = exp_err;
        e.led = exp_led;
        evq.push_back(e);
        SS = 1'b0;
        wait_clk(8);
        for (int i = 0; i < nbits; i++) begin
            MOSI = (i < 8) ? cmd[7-i] : 1'b0;
            if (i == chg_bit) X_POS = chg_x;
            wait_clk(8);
            SCLK = 1'b1;
            wait_clk(8);
            SCLK = 1'b0;
        end
        wait_clk(8);
        SS = 1'b1;
        wait_clk(24);
    endtask

    // MISO monitor: master sample point is the SCLK rise.
    initial forever begin
        @(posedge SCLK);
        if (RST && !SS) begin
            if (bq.size() == 0) begin
                checks++;
                $display("FAIL miso_extra_bit: got unexpected SCLK rise at %0t", $time);
            end else begin
                chk("miso_bit", {7'b0, MISO}, {7'b0, bq.pop_front()});
            end
        end
    end

    // Frame-event monitor: kind of pulse, single-cycle width, LED afterwards.
    initial forever begin
        ev_t e;
        @(negedge CLK);
        if (RST && (FRAME_DONE || FRAME_ERR)) begin
            if (evq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_pulse: got done=%0b err=%0b expected none at %0t",
                         FRAME_DONE, FRAME_ERR, $time);
            end else begin
                e = evq.pop_front();
                chk("pulse_kind", {6'b0, FRAME_DONE, FRAME_ERR}, e.err ? 8'h01 : 8'h02);
                @(negedge CLK);
                chk("pulse_width", {6'b0, FRAME_DONE, FRAME_ERR}, 8'h00);
                chk("led_after_frame", {6'b0, LED}, {6'b0, e.led});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // 1: reset held with SS low and SCLK toggling
        RST = 1'b0;
        SS  = 1'b0;
        wait_clk(2);
        for (int i = 0; i < 4; i++) begin
            SCLK = 1'b1; wait_clk(4);
            chk("reset_miso", {7'b0, MISO}, 8'h00);
            chk("reset_led", {6'b0, LED}, 8'h00);
            chk("reset_pulses", {6'b0, FRAME_DONE, FRAME_ERR}, 8'h00);
            SCLK = 1'b0; wait_clk(4);
        end
        SS = 1'b1;
        wait_clk(4);
        RST = 1'b1;
        wait_clk(10);

        // 2: clean frame, valid LED command 0x83
        X_POS = 10'h2A5; Y_POS = 10'h1C3; BTN = 3'b101;
        frame(40, 8'h83, 40'hA5_02_C3_01_05, -1, 10'h0, 1'b0, 2'b11);
        // 3: bad prefix 0x43, LED kept
        frame(40, 8'h43, 40'hA5_02_C3_01_05, -1, 10'h0, 1'b0, 2'b11);
        // 4: abort after 17 bits, then a clean frame with 0x81
        frame(17, 8'h80, 40'hA5_02_C3_01_05, -1, 10'h0, 1'b1, 2'b11);
        frame(40, 8'h81, 40'hA5_02_C3_01_05, -1, 10'h0, 1'b0, 2'b01);
        // 5: overrun by one SCLK pulse
        frame(41, 8'h82, 40'hA5_02_C3_01_05, -1, 10'h0, 1'b1, 2'b01);
        // 6: X changes mid-frame, only the next frame sees it
        X_POS = 10'h000;
        frame(40, 8'h83, 40'h00_00_C3_01_05, 3, 10'h3FF, 1'b0, 2'b11);
        frame(40, 8'h00, 40'hFF_03_C3_01_05, -1, 10'h0, 1'b0, 2'b11);

        wait_clk(20);
        chk("events_drained", 8'(evq.size()), 8'h00);
        chk("bits_drained", 8'(bq.size()), 8'h00);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
